// File: rtl/rx_hexword.sv
// rx_hexword: parses "0x%08x\r\n" or bare-hex ASCII lines from a UART byte stream into 32-bit words.
// Optional macro RX_HEXWORD_UPPERCASE_EN also accepts 'A'-'F' digits and an 'X' prefix.
module rx_hexword #(
    parameter int TIMEOUT = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_data,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_err,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ZERO,
        S_HEX,
        S_DISCARD
    } state_t;

    localparam logic [23:0] TMO_LAST = (TIMEOUT > 0) ? 24'(TIMEOUT - 1) : 24'd0;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        stb_q, stb_d;
    logic        err_q, err_d;
    logic [23:0] tmo_q, tmo_d;

    logic        rxIsHex;
    logic [3:0]  rxDigit;
    logic        rxIsTerm;
    logic        rxIsSpace;
    logic        rxIsPrefix;
    logic        rxIsZero;

    always_comb begin
        rxIsHex = 1'b0;
        rxDigit = 4'd0;
        if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
            rxIsHex = 1'b1;
            rxDigit = 4'(i_rx_data - 8'h30);
        end else if (i_rx_data >= 8'h61 && i_rx_data <= 8'h66) begin
            rxIsHex = 1'b1;
            rxDigit = 4'(i_rx_data - 8'h57);
        end
`ifdef RX_HEXWORD_UPPERCASE_EN
        else if (i_rx_data >= 8'h41 && i_rx_data <= 8'h46) begin
            rxIsHex = 1'b1;
            rxDigit = 4'(i_rx_data - 8'h37);
        end
`endif
    end

`ifdef RX_HEXWORD_UPPERCASE_EN
    assign rxIsPrefix = (i_rx_data == 8'h78) || (i_rx_data == 8'h58);
`else
    assign rxIsPrefix = (i_rx_data == 8'h78);
`endif
    assign rxIsTerm  = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    assign rxIsSpace = (i_rx_data == 8'h20);
    assign rxIsZero  = (i_rx_data == 8'h30);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= 4'd0;
            data_q  <= 32'd0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // A received byte always takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 24'd0;

        if (i_rx_stb) begin
            case (state_q)
                S_IDLE: begin
                    if (rxIsZero) begin
                        state_d = S_ZERO;
                        acc_d   = 32'd0;
                        cnt_d   = 4'd1;
                    end else if (rxIsHex) begin
                        state_d = S_HEX;
                        acc_d   = {28'd0, rxDigit};
                        cnt_d   = 4'd1;
                    end else if (!rxIsTerm && !rxIsSpace) begin
                        state_d = S_DISCARD;
                    end
                end
                S_ZERO: begin
                    if (rxIsPrefix) begin
                        state_d = S_HEX;
                        acc_d   = 32'd0;
                        cnt_d   = 4'd0;
                    end else if (rxIsHex) begin
                        state_d = S_HEX;
                        acc_d   = {acc_q[27:0], rxDigit};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (rxIsTerm) begin
                        state_d = S_IDLE;
                        data_d  = 32'd0;
                        stb_d   = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_HEX: begin
                    if (rxIsHex && cnt_q < 4'd8) begin
                        acc_d = {acc_q[27:0], rxDigit};
                        cnt_d = cnt_q + 4'd1;
                    end else if (rxIsTerm && cnt_q != 4'd0) begin
                        state_d = S_IDLE;
                        data_d  = acc_q;
                        stb_d   = 1'b1;
                    end else if (rxIsTerm) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                default: begin
                    if (rxIsTerm) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            endcase
        end else if (TIMEOUT > 0 && state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                acc_d   = 32'd0;
                cnt_d   = 4'd0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 24'd1;
            end
        end
    end

    assign o_stb  = stb_q;
    assign o_err  = err_q;
    assign o_data = data_q;
    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_hexword.sv
// Self-checking bench for rx_hexword: directed lines, scoreboard of expected words/errors with latency windows.
module tb_rx_hexword;

    localparam int EXP_NONE = 0;
    localparam int EXP_WORD = 1;
    localparam int EXP_ERR  = 2;

    typedef struct {
        bit          isErr;
        logic [31:0] data;
        int          dueMin;
        int          dueMax;
    } expect_t;

    logic        clock;
    logic        reset;
    logic        rxStb;
    logic [7:0]  rxData;
    logic        outStb;
    logic [31:0] outData;
    logic        outErr;
    logic        outBusy;

    expect_t     scoreboard[$];
    int          cycleCnt;
    int          checkCnt;
    int          passCnt;
    int          lastByteCycle;

    rx_hexword #(.TIMEOUT(16)) dut (
        .i_clk     (clock),
        .i_reset   (reset),
        .i_rx_stb  (rxStb),
        .i_rx_data (rxData),
        .o_stb     (outStb),
        .o_data    (outData),
        .o_err     (outErr),
        .o_busy    (outBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cycleCnt = 0;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCnt++;
        assert (observed === expected) passCnt++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Drives one byte per cycle; the first terminator in the line carries the expectation.
    task automatic applyStimulus(input string line, input int kind, input logic [31:0] word);
        bit pushed;
        expect_t e;
        pushed = 1'b0;
        for (int i = 0; i < line.len(); i++) begin
            @(negedge clock);
            rxStb  = 1'b1;
            rxData = line[i];
            lastByteCycle = cycleCnt;
            if (!pushed && kind != EXP_NONE && (line[i] == 8'h0D || line[i] == 8'h0A)) begin
                e.isErr  = (kind == EXP_ERR);
                e.data   = word;
                e.dueMin = cycleCnt + 1;
                e.dueMax = cycleCnt + 1;
                scoreboard.push_back(e);
                pushed = 1'b1;
            end
        end
        @(negedge clock);
        rxStb  = 1'b0;
        rxData = 8'h00;
    endtask

    task automatic waitDrain(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (scoreboard.size() != 0 && n < maxCycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, 32'(scoreboard.size()), 32'd0);
    endtask

    always @(negedge clock) begin
        if (!reset && (outStb || outErr)) begin
            checkOutput("exclusive", {31'd0, outStb & outErr}, 32'd0);
            if (scoreboard.size() == 0) begin
                checkOutput("spurious", {30'd0, outStb, outErr}, 32'd0);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput("kind_err", {31'd0, outErr}, {31'd0, e.isErr});
                if (!e.isErr) checkOutput("word", outData, e.data);
                checkOutput("latency", {31'd0, (cycleCnt >= e.dueMin && cycleCnt <= e.dueMax)}, 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] time limit expired");
    end

    initial begin
        expect_t e;
        checkCnt = 0;
        passCnt  = 0;
        reset    = 1'b1;
        rxStb    = 1'b0;
        rxData   = 8'h00;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_stb", {31'd0, outStb}, 32'd0);
        checkOutput("reset_err", {31'd0, outErr}, 32'd0);
        checkOutput("reset_data", outData, 32'd0);
        checkOutput("reset_busy", {31'd0, outBusy}, 32'd0);

        applyStimulus("0x12345678\015\n", EXP_WORD, 32'h12345678);
        applyStimulus("0xdeadbeef\n", EXP_WORD, 32'hDEADBEEF);
        applyStimulus("7\015", EXP_WORD, 32'h00000007);
        applyStimulus("0x123456789\015", EXP_ERR, 32'h0);
        waitDrain("drain_overflow", 10);
        checkOutput("data_held", outData, 32'h00000007);

        applyStimulus("0xg1\015", EXP_ERR, 32'h0);
        applyStimulus("0x\015", EXP_ERR, 32'h0);
        applyStimulus("0\015", EXP_WORD, 32'h00000000);
        applyStimulus(" \015\n\n", EXP_NONE, 32'h0);
        waitDrain("drain_short", 10);

        applyStimulus("0x12", EXP_NONE, 32'h0);
        e.isErr  = 1'b1;
        e.data   = 32'h0;
        e.dueMin = lastByteCycle + 16;
        e.dueMax = lastByteCycle + 18;
        scoreboard.push_back(e);
        checkOutput("busy_midline", {31'd0, outBusy}, 32'd1);
        waitDrain("drain_timeout", 30);
        checkOutput("busy_after_timeout", {31'd0, outBusy}, 32'd0);
        applyStimulus("0x34\015", EXP_WORD, 32'h00000034);
        waitDrain("drain_after_timeout", 10);

        applyStimulus("0xab", EXP_NONE, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midreset_data", outData, 32'd0);
        checkOutput("midreset_busy", {31'd0, outBusy}, 32'd0);
        checkOutput("midreset_pulses", {30'd0, outStb, outErr}, 32'd0);
`ifdef RX_HEXWORD_UPPERCASE_EN
        applyStimulus("0xAB\015", EXP_WORD, 32'h000000AB);
`else
        applyStimulus("0xAB\015", EXP_ERR, 32'h0);
`endif
        waitDrain("drain_final", 10);
        repeat (20) @(negedge clock);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/rx_hexword.md
Name: rx_hexword

Overview:
- Receive-side counterpart of the hex-word transmitter.
- Consumes the byte stream from a UART receiver and parses ASCII lines of the form "0x%08x\r\n", or bare hex digits, into 32-bit words.
- Emits each parsed word with a one-cycle strobe. Flags malformed lines with a one-cycle error strobe.
- Sits between rxuart and any consumer of command/data words.

Parameters:
- TIMEOUT, 0, inter-character timeout in i_clk cycles while mid-line; 0 disables. Max 2^24-1.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_rx_stb  input  1  one-cycle strobe, new byte valid on i_rx_data
- i_rx_data  input  8  received byte
- o_stb  output  1  one-cycle pulse: o_data holds a newly parsed word
- o_data  output  32  last parsed word, held until next o_stb
- o_err  output  1  one-cycle pulse: malformed line discarded
- o_busy  output  1  high while not in S_IDLE (mid-line)

Behaviour:
- Clock and reset: reset i_reset, synchronous, active-high; clock i_clk.
- Reset values: state S_IDLE, o_stb=0, o_err=0, o_data=0, accumulator=0, digit count=0, timeout counter=0. Reset mid-line drops the partial line silently.
- Byte classes:
  - hex: '0'-'9' and 'a'-'f', value 0-15.
  - terminator: '\r' (0x0D) or '\n' (0x0A).
  - space: 0x20.
  - other: any remaining byte.
- Shift rule: acc <= {acc[27:0], digit}; cnt <= cnt+1. cnt is 4 bits, range 0..8.
- S_IDLE:
  - '0' -> S_ZERO, acc=0, cnt=1.
  - other hex -> S_HEX, acc=digit, cnt=1.
  - terminator or space -> stay, no output. Empty lines and "\r\n" pairs are silent.
  - other -> S_DISCARD.
- S_ZERO:
  - 'x' -> S_HEX, acc=0, cnt=0.
  - hex -> S_HEX via shift rule.
  - terminator -> emit 0, S_IDLE.
  - other -> S_DISCARD.
- S_HEX:
  - hex with cnt<8 -> shift.
  - hex with cnt==8 -> S_DISCARD (overflow).
  - terminator with cnt>=1 -> emit acc, S_IDLE.
  - terminator with cnt==0 ("0x" alone) -> o_err, S_IDLE.
  - other -> S_DISCARD.
- S_DISCARD:
  - terminator -> o_err pulse, S_IDLE.
  - all else ignored.
- Emit: o_data <= acc (or 0 from S_ZERO), o_stb=1 for one cycle.
- Latency: o_stb/o_err assert the cycle after the i_rx_stb carrying the terminator.
- o_stb and o_err are never high together.
- Fewer than 8 digits are right-aligned; "0xff" yields 0x000000FF.
- The '\n' following a '\r' lands in S_IDLE and is ignored.
- Bytes without i_rx_stb are ignored. Back-to-back i_rx_stb on consecutive cycles must be accepted.
- Timeout (TIMEOUT>0):
  - Counter clears on every i_rx_stb and in S_IDLE; increments otherwise.
  - On reaching TIMEOUT with state != S_IDLE: o_err pulse, return to S_IDLE, acc=0.
  - If i_rx_stb arrives in the same cycle the timeout fires, the byte wins and the timeout is suppressed.
- o_busy = (state != S_IDLE), combinational from state.

Optional Feature:
- Macro RX_HEXWORD_UPPERCASE_EN.
- Defined: 'A'-'F' also classify as hex, values 10-15, and 'X' is accepted as a prefix equivalent to 'x'.
- Undefined: 'A'-'F' and 'X' are "other" and send the line to S_DISCARD.

Test Plan:
- Bytes "0x12345678\r\n", back-to-back strobes -> single o_stb with o_data=0x12345678 one cycle after '\r'; no o_err; '\n' silent.
- "0xdeadbeef\n" then "7\r" -> o_stb with 0xDEADBEEF, then o_stb with 0x00000007.
- "0x123456789\r" (9 digits) -> no o_stb, one o_err after '\r'; o_data unchanged from previous word.
- "0xg1\r" and "0x\r" -> one o_err each, no o_stb; "0\r" -> o_stb with o_data=0.
- TIMEOUT=16: "0x12" then 16 idle cycles -> o_err, o_busy falls; next "0x34\r" -> o_stb with 0x34.
- Reset asserted after "0xab" -> outputs zero, no o_stb/o_err; "0xAB\r" -> 0xAB only with RX_HEXWORD_UPPERCASE_EN, else o_err.
